serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub.sv | 104 ++++++++++
 tb/tb_serial_addsub.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder step per cycle, LSB first, N cycles per operation.
// Optional overflow flag enabled by defining SERIAL_ADDSUB_OVF_EN; otherwise ovf is tied to 0.
module serial_addsub #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         add_ns,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, b_q, s_q;
  logic           add_q, carry_q, cout_q;
  logic [CW-1:0]  cnt_q;
  logic           b_bit, sum_bit, carry_next, last_bit;

  // Subtraction is a + ~b + 1: the +1 comes from the carry preset at start.
  always_comb begin
    b_bit      = add_q ? b_q[0] : ~b_q[0];
    sum_bit    = a_q[0] ^ b_bit ^ carry_q;
    carry_next = (a_q[0] & b_bit) | (a_q[0] & carry_q) | (b_bit & carry_q);
    last_bit   = (cnt_q == CW'(N - 1));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      add_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            add_q   <= add_ns;
            carry_q <= ~add_ns;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          s_q     <= {sum_bit, s_q[N-1:1]};
          carry_q <= carry_next;
          if (last_bit) cout_q <= carry_next;
          else          cnt_q  <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_q;

  // On the MSB step carry_q is the carry into the MSB and carry_next the carry out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                ovf_q <= 1'b0;
    else if (state_q == StRun && last_bit)  ovf_q <= carry_q ^ carry_next;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign s    = s_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Randomized and directed self-checking bench for serial_addsub (N=8) against an arithmetic model.
module tb_serial_addsub;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         add_ns = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy, done, cout, ovf;
  logic [N-1:0] s;

  int n_tests = 0;
  int n_fail  = 0;

  serial_addsub #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .add_ns (add_ns),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .s      (s),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on the operand values.
  task automatic model(input logic op_add, input logic [N-1:0] av, input logic [N-1:0] bv,
                       output logic [N-1:0] es, output logic ec, output logic eo);
    longint sa, sb, r, max_v, min_v;
    sa    = longint'($signed(av));
    sb    = longint'($signed(bv));
    r     = op_add ? sa + sb : sa - sb;
    max_v = (longint'(1) << (N - 1)) - 1;
    min_v = -(longint'(1) << (N - 1));
    es    = N'(r);
    if (op_add) ec = ((longint'(av) + longint'(bv)) >= (longint'(1) << N));
    else        ec = (av >= bv);
`ifdef SERIAL_ADDSUB_OVF_EN
    eo = (r > max_v) || (r < min_v);
`else
    eo = 1'b0;
`endif
  endtask

  task automatic do_op(input logic op_add, input logic [N-1:0] av, input logic [N-1:0] bv,
                       input bit pulse_mid);
    logic [N-1:0] es;
    logic         ec, eo;
    int           lat;
    model(op_add, av, bv, es, ec, eo);
    @(negedge clk);
    start = 1'b1; add_ns = op_add; a = av; b = bv;
    @(posedge clk); #1;
    check("busy_after_start", busy, 1);
    start = 1'b0;
    add_ns = 1'($urandom()); a = N'($urandom()); b = N'($urandom());
    lat = 0;
    while (lat < 3 * N) begin
      @(posedge clk); #1;
      lat++;
      if (pulse_mid) start = (lat == 3);
      if (done) break;
    end
    start = 1'b0;
    check("latency", lat, N);
    check("s", s, es);
    check("cout", cout, ec);
    check("ovf", ovf, eo);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
    check("s_hold", s, es);
    check("cout_hold", cout, ec);
  endtask

  initial begin
    logic         op_add_v[3];
    logic [N-1:0] op_a_v[3], op_b_v[3];
    logic [N-1:0] es;
    logic         ec, eo;
    int           k, cyc, last_done;

    // Reset state
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_s", s, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk); rst = 1'b0;

    // Directed cases
    do_op(1'b1, 8'h05, 8'h03, 1'b0);
    do_op(1'b1, 8'hFF, 8'h01, 1'b0);
    do_op(1'b0, 8'h05, 8'h03, 1'b0);
    do_op(1'b0, 8'h03, 8'h05, 1'b0);
    do_op(1'b1, 8'h7F, 8'h01, 1'b0);
    do_op(1'b0, 8'h80, 8'h01, 1'b0);
    do_op(1'b1, 8'h3C, 8'h5A, 1'b1);

    // Reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; add_ns = 1'b1; a = 8'hAA; b = 8'h55;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_s", s, 0);
    check("mid_rst_cout", cout, 0);
    check("mid_rst_ovf", ovf, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    do_op(1'b1, 8'h10, 8'h20, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      check("no_spurious_done", done, 0);
    end

    // Random operations
    for (int i = 0; i < 25; i++) begin
      do_op(1'($urandom()), N'($urandom()), N'($urandom()), 1'($urandom()));
    end

    // start held high: back-to-back operations
    for (int i = 0; i < 3; i++) begin
      op_add_v[i] = 1'($urandom());
      op_a_v[i]   = N'($urandom());
      op_b_v[i]   = N'($urandom());
    end
    @(negedge clk);
    start = 1'b1; add_ns = op_add_v[0]; a = op_a_v[0]; b = op_b_v[0];
    k = 0; cyc = 0; last_done = 0;
    while (k < 3 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        model(op_add_v[k], op_a_v[k], op_b_v[k], es, ec, eo);
        check("b2b_s", s, es);
        check("b2b_cout", cout, ec);
        check("b2b_ovf", ovf, eo);
        if (k > 0) check("b2b_spacing", cyc - last_done, N + 2);
        last_done = cyc;
        k++;
        if (k < 3) begin
          add_ns = op_add_v[k]; a = op_a_v[k]; b = op_b_v[k];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_count", k, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
